// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII code points used by the text formatters and
// the state encoding of the hex transmit formatter.
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble-to-ASCII converter: 0-9 map to '0'-'9', 10-15 map to
// 'A'-'F' or 'a'-'f' depending on the lowercase select.
module hex_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lowercase,
  output logic [7:0] ascii
);

  logic [7:0] letter_base;

  always_comb begin
    letter_base = lowercase ? ASCII_LA : ASCII_UA;
    if (nibble <= 4'd9) begin
      ascii = ASCII_0 + {4'b0000, nibble};
    end else begin
      ascii = letter_base + {4'b0000, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_tx_formatter.sv
// Reports one byte as two ASCII hex characters (optionally followed by CR LF)
// through a UART_TX-style start/busy/done handshake, one character at a time.
module uart_hex_tx_formatter
  import uart_pkg::*;
#(
  parameter bit APPEND_CRLF = 1'b1,
  parameter bit LOWERCASE   = 1'b0
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_VALID,
  input  logic [7:0] i_DATA,
  output logic       o_READY,
  output logic       o_BUSY,
  output logic       o_tx_DATA_READY,
  output logic [7:0] o_tx_DATA,
  input  logic       i_tx_BUSY,
  input  logic       i_tx_DONE
);

  localparam logic [1:0] LAST_INDEX = APPEND_CRLF ? 2'd3 : 2'd1;

  logic [1:0] state_reg;
  logic [1:0] index_reg;
  logic [7:0] data_reg;
  logic [7:0] tx_data_reg;

  logic [1:0] char_index;
  logic [7:0] char_src;
  logic [3:0] nibble;
  logic [7:0] hex_char;
  logic [7:0] next_char;

  // The character register is loaded one step ahead: from i_DATA on accept,
  // otherwise from the latched byte at the following index.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      char_index = 2'd0;
      char_src   = i_DATA;
    end else begin
      char_index = index_reg + 2'd1;
      char_src   = data_reg;
    end
    nibble = char_index[0] ? char_src[3:0] : char_src[7:4];
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble    (nibble),
    .lowercase (LOWERCASE),
    .ascii     (hex_char)
  );

  always_comb begin
    case (char_index)
      2'd2:    next_char = ASCII_CR;
      2'd3:    next_char = ASCII_LF;
      default: next_char = hex_char;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_reg   <= ST_IDLE;
      index_reg   <= 2'd0;
      data_reg    <= 8'h00;
      tx_data_reg <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_VALID) begin
            data_reg    <= i_DATA;
            index_reg   <= 2'd0;
            tx_data_reg <= next_char;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i_tx_BUSY) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_tx_DONE) begin
            if (index_reg == LAST_INDEX) begin
              state_reg <= ST_IDLE;
            end else begin
              index_reg   <= index_reg + 2'd1;
              tx_data_reg <= next_char;
              state_reg   <= ST_ISSUE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Start pulse is qualified by the live busy flag so it fires in the first
  // ISSUE cycle in which the transmitter can take the character.
  assign o_tx_DATA_READY = (state_reg == ST_ISSUE) && !i_tx_BUSY;
  assign o_READY         = (state_reg == ST_IDLE);
  assign o_BUSY          = !o_READY;
  assign o_tx_DATA       = tx_data_reg;

endmodule

// File: tb/tb_uart_hex_tx_formatter.sv
// Bench for uart_hex_tx_formatter: instance 0 uses defaults, instance 1 uses
// LOWERCASE=1/APPEND_CRLF=0; a scoreboard checks every character pulse.
module tb_uart_hex_tx_formatter;

  typedef struct packed {
    logic       inst;
    logic [7:0] ch;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       valid      [2];
  logic [7:0] data       [2];
  logic       ready      [2];
  logic       busy_out   [2];
  logic       tx_ready   [2];
  logic [7:0] tx_data    [2];
  logic       tx_busy    [2];
  logic       tx_done    [2];
  logic       force_busy [2];
  logic       inject_done[2];
  logic       model_done [2];
  logic [5:0] model_cnt  [2];

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   pulse_cnt[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      uart_hex_tx_formatter #(
        .APPEND_CRLF (gi == 0),
        .LOWERCASE   (gi == 1)
      ) dut (
        .i_CLK           (clk),
        .i_RESET         (rst_n),
        .i_VALID         (valid[gi]),
        .i_DATA          (data[gi]),
        .o_READY         (ready[gi]),
        .o_BUSY          (busy_out[gi]),
        .o_tx_DATA_READY (tx_ready[gi]),
        .o_tx_DATA       (tx_data[gi]),
        .i_tx_BUSY       (tx_busy[gi]),
        .i_tx_DONE       (tx_done[gi])
      );

      // Behavioural UART_TX: busy for 20 cycles after a start pulse, then done.
      always @(posedge clk) begin
        model_done[gi] <= 1'b0;
        if (!rst_n) begin
          model_cnt[gi] <= 6'd0;
        end else if (tx_ready[gi]) begin
          model_cnt[gi] <= 6'd20;
        end else if (model_cnt[gi] != 6'd0) begin
          model_cnt[gi] <= model_cnt[gi] - 6'd1;
          if (model_cnt[gi] == 6'd1) model_done[gi] <= 1'b1;
        end
      end

      assign tx_busy[gi] = (model_cnt[gi] != 6'd0) || force_busy[gi];
      assign tx_done[gi] = model_done[gi] || inject_done[gi];
    end
  endgenerate

  // Monitor: every start pulse pops one expected character.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (tx_ready[i]) begin
          exp_t e;
          pulse_cnt[i]++;
          checks++;
          if (tx_busy[i]) begin
            failures++;
            $display("FAIL pulse_while_busy inst%0d: got pulse expected none", i);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse inst%0d: got char 0x%02h expected no pulse", i, tx_data[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != 1'(i) || e.ch !== tx_data[i]) begin
              failures++;
              $display("FAIL char inst%0d: got 0x%02h expected inst%0d 0x%02h", i, tx_data[i], e.inst, e.ch);
            end else begin
              $display("char inst%0d 0x%02h ok", i, tx_data[i]);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s = 0x%0h ok", name, act);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] ch);
    exp_t e;
    e.inst = 1'(inst);
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic send(input int inst, input logic [7:0] d);
    @(posedge clk); #1;
    valid[inst] = 1'b1;
    data[inst]  = d;
    @(posedge clk); #1;
    valid[inst] = 1'b0;
    data[inst]  = 8'hA5;
  endtask

  task automatic wait_idle(input int inst, input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready[inst] && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle_reached"}, 32'(ready[inst]), 32'd1);
  endtask

  task automatic check_reset_outputs(input int inst, input string name);
    check({name, "_ready"},    32'(ready[inst]),    32'd1);
    check({name, "_busy"},     32'(busy_out[inst]), 32'd0);
    check({name, "_tx_ready"}, 32'(tx_ready[inst]), 32'd0);
    check({name, "_tx_data"},  32'(tx_data[inst]),  32'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int dn;
    int bad;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; data[i] = 8'h00; force_busy[i] = 1'b0;
      inject_done[i] = 1'b0; pulse_cnt[i] = 0;
    end

    // 1: reset, then a stray done in IDLE
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs(0, "rst_i0");
    check_reset_outputs(1, "rst_i1");
    inject_done[0] = 1'b1;
    @(posedge clk); #1;
    inject_done[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_done_ready", 32'(ready[0]), 32'd1);
    check("idle_done_tx_data", 32'(tx_data[0]), 32'h00);
    check("idle_done_pulses", 32'(pulse_cnt[0]), 32'd0);

    // 2: 0x4F with CR LF, ready one cycle after the 4th done
    p0 = pulse_cnt[0];
    push(0, 8'h34); push(0, 8'h46); push(0, 8'h0D); push(0, 8'h0A);
    send(0, 8'h4F);
    check("accept_busy", 32'(busy_out[0]), 32'd1);
    check("accept_tx_data", 32'(tx_data[0]), 32'h34);
    dn = 0;
    for (int k = 0; k < 500 && dn < 4; k++) begin
      @(posedge clk); #1;
      if (tx_done[0]) begin
        dn++;
        if (dn == 4) begin
          check("last_done_ready_low", 32'(ready[0]), 32'd0);
          @(posedge clk); #1;
          check("ready_after_last_done", 32'(ready[0]), 32'd1);
        end
      end
    end
    check("t2_done_count", 32'(dn), 32'd4);
    check("t2_pulses", 32'(pulse_cnt[0] - p0), 32'd4);

    // 3: lowercase, no CR LF
    p0 = pulse_cnt[1];
    push(1, 8'h61); push(1, 8'h62);
    send(1, 8'hAB);
    wait_idle(1, "t3");
    repeat (25) @(posedge clk);
    #1;
    check("t3_pulses", 32'(pulse_cnt[1] - p0), 32'd2);
    check("t3_ready", 32'(ready[1]), 32'd1);

    // 4: transmitter busy for 50 cycles at accept
    push(0, 8'h30); push(0, 8'h39); push(0, 8'h0D); push(0, 8'h0A);
    force_busy[0] = 1'b1;
    send(0, 8'h09);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx_ready[0]) bad++;
      if (k < 49) begin
        @(posedge clk); #1;
      end
    end
    check("t4_no_pulse_while_busy", 32'(bad), 32'd0);
    @(posedge clk); #1;
    force_busy[0] = 1'b0;
    #1;
    check("t4_pulse_after_busy", 32'(tx_ready[0]), 32'd1);
    check("t4_tx_data", 32'(tx_data[0]), 32'h30);
    wait_idle(0, "t4");

    // 5: second request held high during a message
    push(0, 8'h46); push(0, 8'h30); push(0, 8'h0D); push(0, 8'h0A);
    push(0, 8'h31); push(0, 8'h32); push(0, 8'h0D); push(0, 8'h0A);
    send(0, 8'hF0);
    valid[0] = 1'b1;
    data[0]  = 8'h12;
    for (int k = 0; k < 500 && !ready[0]; k++) begin
      @(posedge clk); #1;
    end
    check("t5_ready_with_valid", 32'(ready[0]), 32'd1);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    data[0]  = 8'h00;
    check("t5_second_accept", 32'(busy_out[0]), 32'd1);
    check("t5_second_first_char", 32'(tx_data[0]), 32'h31);
    wait_idle(0, "t5");

    // 6: reset after 2nd done of 0x7E, then a clean 0x00 message
    push(0, 8'h37); push(0, 8'h45);
    send(0, 8'h7E);
    dn = 0;
    for (int k = 0; k < 500 && dn < 2; k++) begin
      @(posedge clk); #1;
      if (tx_done[0]) dn++;
    end
    check("t6_done_count", 32'(dn), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "t6_async_rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 8'h30); push(0, 8'h30); push(0, 8'h0D); push(0, 8'h0A);
    send(0, 8'h00);
    wait_idle(0, "t6");
    repeat (30) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_hex_tx_formatter.md
# uart_hex_tx_formatter

Converts one 8-bit value into its two-character ASCII hex representation and sends the characters, optionally followed by CR LF, through the existing UART_TX block. It sits between any byte producer (switches, counters, debug registers) and UART_TX. It is the PC-bound reporting path: the receive side shows ASCII hex on the seven-segment display, and this block sends hex as ASCII text to the terminal.

## Interface
Parameters:
- APPEND_CRLF, 1: 1 appends 0x0D, 0x0A after the two hex characters (4 chars/message); 0 sends 2 chars/message.
- LOWERCASE, 0: 1 selects 'a'–'f' (0x61–0x66); 0 selects 'A'–'F' (0x41–0x46).

Ports:
- i_CLK  in  1  single system clock; all logic on rising edge.
- i_RESET  in  1  asynchronous, active-low reset.
- i_VALID  in  1  request to report i_DATA.
- i_DATA  in  8  byte to report; sampled only on accept.
- o_READY  out  1  idle and able to accept; accept = i_VALID & o_READY.
- o_BUSY  out  1  message in progress (= ~o_READY).
- o_tx_DATA_READY  out  1  one-cycle start pulse to UART_TX i_tx_DATA_READY.
- o_tx_DATA  out  8  character to UART_TX i_tx_DATA.
- i_tx_BUSY  in  1  from UART_TX o_tx_BUSY.
- i_tx_DONE  in  1  from UART_TX o_tx_DONE (one-cycle pulse per character).

## Operation
- States:
  - IDLE: o_READY=1. On accept, latch i_DATA, set char index to 0, and go to ISSUE.
  - ISSUE: drive the character for the current index on o_tx_DATA. When i_tx_BUSY=0, pulse o_tx_DATA_READY for one cycle and go to WAIT. While i_tx_BUSY=1, stay in ISSUE and do not pulse.
  - WAIT: on i_tx_DONE, if index = last, go to IDLE; otherwise increment index and go to ISSUE.
- Char order: index 0 = hex(byte[7:4]), 1 = hex(byte[3:0]), 2 = 0x0D, 3 = 0x0A. Last index = 3 if APPEND_CRLF, else 1.
- Nibble mapping: n≤9 → 0x30+n. n≥10 → 0x41+(n−10), or 0x61+(n−10) when LOWERCASE.
- o_tx_DATA is registered. It stays stable from the ISSUE entry cycle until the cycle after the corresponding i_tx_DONE.
- Exactly one o_tx_DATA_READY pulse per character; never two pulses without an intervening i_tx_DONE.
- Boundary cases:
  - i_VALID while busy: ignored, no queuing.
  - i_DATA changes after accept: no effect.
  - i_tx_DONE in IDLE or ISSUE: ignored.
  - i_RESET low mid-message: immediate return to IDLE with all outputs at reset values; the partial message is abandoned and not resumed.

## Timing
- Reset values: o_READY=1, o_BUSY=0, o_tx_DATA_READY=0, o_tx_DATA=0x00, state IDLE, index 0.
- Accept at cycle N → o_tx_DATA valid at N+1 → o_tx_DATA_READY pulse at N+1 if i_tx_BUSY=0, otherwise in the first cycle with i_tx_BUSY=0.
- i_tx_DONE at cycle M (not last char) → next character on o_tx_DATA at M+1, with the pulse at M+1 at the earliest.
- i_tx_DONE of last char at cycle M → o_READY=1 at M+1. If i_VALID is high at M, it is not accepted; the earliest accept is M+1.
- Per-message latency: one cycle plus 2 or 4 UART character times, plus one cycle per character of handshake.

## Structure
- Shared package uart_pkg:
  - ASCII constants ASCII_0=0x30, ASCII_UA=0x41, ASCII_LA=0x61, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - FSM state encoding (IDLE, ISSUE, WAIT).
- One combinational sub-module, hex_to_ascii (4-bit nibble + lowercase select → 8-bit char), instantiated once on the index-muxed nibble.
- Top-level integration: a new top that ties o_tx_* / i_tx_* to UART_TX. UART_TX and UART_RX are reused unmodified.

## Test plan
Tests 2–6 use a behavioural UART_TX model: i_tx_BUSY high for 20 cycles after each pulse, then a one-cycle i_tx_DONE.
1. Reset held low, then released → o_READY=1, o_BUSY=0, o_tx_DATA_READY=0, o_tx_DATA=0x00; a pulse on i_tx_DONE in IDLE produces no output activity.
2. Defaults, accept i_DATA=0x4F → characters 0x34, 0x46, 0x0D, 0x0A, exactly 4 single-cycle pulses; o_READY rises one cycle after the 4th i_tx_DONE.
3. LOWERCASE=1, APPEND_CRLF=0, i_DATA=0xAB → characters 0x61, 0x62, exactly 2 pulses, then IDLE.
4. i_tx_BUSY forced high for 50 cycles at accept of 0x09 → no pulse during those 50 cycles; the pulse arrives the cycle after i_tx_BUSY falls, and o_tx_DATA=0x30.
5. i_VALID with 0x12 held during transmission of 0xF0 → sequence stays 0x46, 0x30, 0x0D, 0x0A; 0x12 is accepted only when o_READY=1, then sent as 0x31, 0x32, 0x0D, 0x0A.
6. Reset asserted after the 2nd i_tx_DONE of 0x7E → outputs return to reset values asynchronously; after release, accept 0x00 → 0x30, 0x30, 0x0D, 0x0A with no leftover CR/LF from the aborted message.
